// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - serialises two parallel operands LSB-first into the serial adder
// Moore machine: clear pulse, N data bit-pairs, FLUSH_BITS zero pairs, then a done pulse.
module serial_operand_feeder #(
   parameter int N          = 8,
   parameter int FLUSH_BITS = 2,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [N-1:0]     op_a,
   input  logic [N-1:0]     op_b,
   output logic             a,
   output logic             b,
   output logic             add_clr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_idx
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(N + FLUSH_BITS - 1);

   logic [2:0]       state;
   logic [N-1:0]     sha;
   logic [N-1:0]     shb;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         sha   <= '0;
         shb   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sha   <= op_a;
                  shb   <= op_b;
                  cnt   <= '0;
                  state <= S_CLEAR;
               end
            end
            S_CLEAR: state <= S_SHIFT;
            S_SHIFT: begin
               sha <= sha >> 1;
               shb <= shb >> 1;
               cnt <= cnt + 1'b1;
               if (cnt == LAST_SHIFT)
                  state <= (FLUSH_BITS > 0) ? S_FLUSH : S_DONE;
            end
            // counter keeps running so bit_idx reports N..N+FLUSH_BITS-1
            S_FLUSH: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST_FLUSH)
                  state <= S_DONE;
            end
            S_DONE: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign a       = (state == S_SHIFT) & sha[0];
   assign b       = (state == S_SHIFT) & shb[0];
   assign add_clr = (state == S_CLEAR);
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);
   assign bit_idx = ((state == S_SHIFT) || (state == S_FLUSH)) ? cnt : '0;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - directed bench for serial_operand_feeder
// u0 runs N=8/FLUSH_BITS=2 with a reference serial adder on its outputs; u1 runs FLUSH_BITS=0.
module tb_serial_operand_feeder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] op_a = '0;
   logic [7:0] op_b = '0;
   logic       a, b, add_clr, busy, done;
   logic [3:0] bit_idx;

   logic       start1 = 1'b0;
   logic [7:0] op_a1 = '0;
   logic [7:0] op_b1 = '0;
   logic       a1, b1, add_clr1, busy1, done1;
   logic [3:0] bit_idx1;

   logic       y, cy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   serial_operand_feeder #(.N(8), .FLUSH_BITS(2), .CNT_W(4)) u0 (
      .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
      .a(a), .b(b), .add_clr(add_clr), .busy(busy), .done(done), .bit_idx(bit_idx)
   );

   serial_operand_feeder #(.N(8), .FLUSH_BITS(0), .CNT_W(4)) u1 (
      .clk(clk), .reset(reset), .start(start1), .op_a(op_a1), .op_b(op_b1),
      .a(a1), .b(b1), .add_clr(add_clr1), .busy(busy1), .done(done1), .bit_idx(bit_idx1)
   );

   // serial adder with registered sum and carry, cleared by add_clr
   always_ff @(posedge clk) begin
      if (add_clr) begin
         y  <= 1'b0;
         cy <= 1'b0;
      end else begin
         y  <= a ^ b ^ cy;
         cy <= (a & b) | (cy & (a ^ b));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b1;
      op_a  = 8'hA5;
      op_b  = 8'h3C;
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++;
         if ({busy, done, a, b, add_clr, bit_idx} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset[%0d]: busy=%b done=%b a=%b b=%b add_clr=%b bit_idx=%0d, required all 0",
                     i, busy, done, a, b, add_clr, bit_idx);
         end
      end
      reset = 1'b0;
      start = 1'b0;
      tick();
      vectors++;
      if (busy !== 1'b0 || add_clr !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: busy=%b add_clr=%b, required 0 0", busy, add_clr);
      end
   endtask

   task automatic test_basic;
      logic [7:0] ea = 8'hA5;
      logic [7:0] eb = 8'h3C;
      int busy_cnt = 0;
      op_a = ea;
      op_b = eb;
      start = 1'b1;
      tick();
      start = 1'b0;
      op_a = 8'h00;
      op_b = 8'h00;
      vectors++;
      if (add_clr !== 1'b1 || busy !== 1'b1 || a !== 1'b0 || b !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_clear: add_clr=%b busy=%b a=%b b=%b, required 1 1 0 0", add_clr, busy, a, b);
      end
      busy_cnt += int'(busy);
      for (int i = 0; i < 10; i++) begin
         tick();
         busy_cnt += int'(busy);
         vectors++;
         if (a !== ((i < 8) ? ea[i] : 1'b0) || b !== ((i < 8) ? eb[i] : 1'b0) ||
             bit_idx !== 4'(i) || add_clr !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_bit%0d: a=%b b=%b bit_idx=%0d add_clr=%b done=%b, required a=%b b=%b bit_idx=%0d 0 0",
                     i, a, b, bit_idx, add_clr, done, (i < 8) ? ea[i] : 1'b0, (i < 8) ? eb[i] : 1'b0, i);
         end
      end
      tick();
      busy_cnt += int'(busy);
      vectors++;
      if (done !== 1'b1 || a !== 1'b0 || bit_idx !== 4'd0) begin
         miscompares++;
         $display("FAIL basic_done: done=%b a=%b bit_idx=%0d, required 1 0 0", done, a, bit_idx);
      end
      tick();
      busy_cnt += int'(busy);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_idle: done=%b busy=%b, required 0 0", done, busy);
      end
      vectors++;
      if (busy_cnt != 12) begin
         miscompares++;
         $display("FAIL basic_busy_len: %0d cycles, required 12", busy_cnt);
      end
   endtask

   task automatic test_start_while_busy;
      logic [7:0] ea = 8'hA5;
      logic [7:0] eb = 8'h3C;
      logic [7:0] na = 8'h69;
      logic [7:0] nb = 8'h96;
      int done_cnt = 0;
      op_a = ea;
      op_b = eb;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            start = 1'b1;
            op_a = 8'hFF;
            op_b = 8'h01;
         end else if (i == 4) begin
            start = 1'b0;
         end else if (i == 7) begin
            start = 1'b1;
            op_a = na;
            op_b = nb;
         end
         tick();
         done_cnt += int'(done);
         vectors++;
         if (a !== ea[i] || b !== eb[i] || bit_idx !== 4'(i)) begin
            miscompares++;
            $display("FAIL busy_start_bit%0d: a=%b b=%b bit_idx=%0d, required a=%b b=%b bit_idx=%0d",
                     i, a, b, bit_idx, ea[i], eb[i], i);
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         done_cnt += int'(done);
      end
      vectors++;
      if (done_cnt != 1) begin
         miscompares++;
         $display("FAIL busy_start_done_count: %0d pulses, required 1", done_cnt);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || add_clr !== 1'b0) begin
         miscompares++;
         $display("FAIL back_to_back_idle: busy=%b add_clr=%b, required 0 0", busy, add_clr);
      end
      tick();
      start = 1'b0;
      op_a = 8'h00;
      op_b = 8'hFF;
      vectors++;
      if (add_clr !== 1'b1) begin
         miscompares++;
         $display("FAIL back_to_back_clear: add_clr=%b, required 1", add_clr);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (a !== na[i] || b !== nb[i]) begin
            miscompares++;
            $display("FAIL back_to_back_bit%0d: a=%b b=%b, required a=%b b=%b", i, a, b, na[i], nb[i]);
         end
      end
      for (int i = 0; i < 4; i++) tick();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL back_to_back_end: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_reset_mid;
      int stray = 0;
      op_a = 8'hA5;
      op_b = 8'h3C;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      vectors++;
      if (bit_idx !== 4'd4) begin
         miscompares++;
         $display("FAIL reset_mid_pos: bit_idx=%0d, required 4", bit_idx);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if ({busy, a, b, add_clr, done, bit_idx} !== 9'b0) begin
         miscompares++;
         $display("FAIL reset_mid: busy=%b a=%b b=%b add_clr=%b done=%b bit_idx=%0d, required all 0",
                  busy, a, b, add_clr, done, bit_idx);
      end
      for (int i = 0; i < 14; i++) begin
         tick();
         stray += int'(done) + int'(busy);
      end
      vectors++;
      if (stray != 0) begin
         miscompares++;
         $display("FAIL reset_mid_quiet: %0d done/busy cycles, required 0", stray);
      end
   endtask

   task automatic test_boundary;
      int busy1_cnt = 0;
      op_a = 8'hFF;
      op_b = 8'hFF;
      op_a1 = 8'hFF;
      op_b1 = 8'hFF;
      start = 1'b1;
      start1 = 1'b1;
      tick();
      start = 1'b0;
      start1 = 1'b0;
      busy1_cnt += int'(busy1);
      for (int i = 0; i < 10; i++) begin
         tick();
         busy1_cnt += int'(busy1);
         vectors++;
         if (a !== (i < 8) || b !== (i < 8)) begin
            miscompares++;
            $display("FAIL ff_bit%0d: a=%b b=%b, required %b %b", i, a, b, i < 8, i < 8);
         end
         if (i < 8) begin
            vectors++;
            if (a1 !== 1'b1 || b1 !== 1'b1 || bit_idx1 !== 4'(i)) begin
               miscompares++;
               $display("FAIL noflush_bit%0d: a=%b b=%b bit_idx=%0d, required 1 1 %0d", i, a1, b1, bit_idx1, i);
            end
         end else if (i == 8) begin
            vectors++;
            if (done1 !== 1'b1 || a1 !== 1'b0) begin
               miscompares++;
               $display("FAIL noflush_done: done=%b a=%b, required 1 0", done1, a1);
            end
         end
      end
      tick();
      busy1_cnt += int'(busy1);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL ff_done: done=%b, required 1", done);
      end
      vectors++;
      if (busy1_cnt != 10) begin
         miscompares++;
         $display("FAIL noflush_busy_len: %0d cycles, required 10", busy1_cnt);
      end
      tick();
   endtask

   task automatic test_adder;
      logic [8:0] sum = '0;
      op_a = 8'h5A;
      op_b = 8'h27;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < 10; j++) begin
         tick();
         if (j >= 1) sum[j-1] = y;
      end
      vectors++;
      if (sum !== 9'h081) begin
         miscompares++;
         $display("FAIL adder_sum: got 9'h%03h, required 9'h081", sum);
      end
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_start_while_busy();
      test_reset_mid();
      test_boundary();
      test_adder();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
